// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: single-cycle hits, whole-line burst refill,
// round-robin replacement, uncached bypass fetches and error-tagged responses.
module icache_nway #(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_flush,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [31:0] io_req_pc,
  input  logic        io_req_bypass,
  output logic        io_rsp_valid,
  output logic [31:0] io_rsp_data,
  output logic        io_rsp_error,
  output logic        io_mem_cmd_valid,
  input  logic        io_mem_cmd_ready,
  output logic [31:0] io_mem_cmd_payload_address,
  output logic [2:0]  io_mem_cmd_payload_size,
  input  logic        io_mem_rsp_valid,
  input  logic [31:0] io_mem_rsp_payload_data,
  input  logic        io_mem_rsp_payload_error,
  output logic        io_stat_miss,
  output logic [2:0]  dbgState
);
  localparam int OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WRD_W  = OFF_W - 2;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int RAM_AW = IDX_W + WRD_W;

  typedef enum logic [2:0] {IDLE, MISS_CMD, REFILL, BYP_CMD, BYP_WAIT, RESP} state_t;
  state_t state;

  logic              lkValid, lkBypass;
  logic [29:0]       lkWa;
  logic [IDX_W-1:0]  lkIdx;
  logic [TAG_W-1:0]  lkTag;
  logic [WRD_W-1:0]  lkWord;
  logic [SETS-1:0]   validBits [WAYS];
  logic [TAG_W-1:0]  tags [WAYS][SETS];
  logic [WAY_W-1:0]  rrPtr [SETS];
  logic [WAY_W-1:0]  victim, vicSel, hitWay, nextPtr;
  logic [WRD_W-1:0]  beatCnt;
  logic              flushPend, errAcc, capErr, hit, vicFound;
  logic [31:0]       capWord;
  logic [WAYS-1:0][31:0] rdWord;
  logic              lookup, lkHit, lkStall, accept, ramWe, lineDone, lineOk;
  logic [RAM_AW-1:0] rdAddr, wrAddr;
  logic              unusedPcBits;

  assign lkWord = lkWa[0 +: WRD_W];
  assign lkIdx  = lkWa[WRD_W +: IDX_W];
  assign lkTag  = lkWa[29 -: TAG_W];
  assign unusedPcBits = ^io_req_pc[1:0];

  always_comb begin
    hit      = 1'b0;
    hitWay   = '0;
    vicFound = 1'b0;
    vicSel   = rrPtr[lkIdx];
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && validBits[w][lkIdx] && tags[w][lkIdx] == lkTag) begin
        hit    = 1'b1;
        hitWay = WAY_W'(w);
      end
      if (!vicFound && !validBits[w][lkIdx]) begin
        vicFound = 1'b1;
        vicSel   = WAY_W'(w);
      end
    end
  end

  // Handshakes: a transfer happens in any cycle where valid && ready are both high at the
  // rising edge; a command holds address/size stable until then. Responses are never stalled.
  assign lookup       = (state == IDLE) && lkValid;
  assign lkHit        = lookup && !lkBypass && hit;
  assign lkStall      = lookup && (lkBypass || !hit);
  assign io_req_ready = reset && (state == IDLE) && !io_flush && !flushPend && !lkStall;
  assign accept       = io_req_valid && io_req_ready;

  assign io_rsp_valid     = lkHit || (state == RESP);
  assign io_rsp_data      = lkHit ? rdWord[hitWay] : ((state == RESP) ? capWord : 32'd0);
  assign io_rsp_error     = (state == RESP) && capErr;
  assign io_mem_cmd_valid = (state == MISS_CMD) || (state == BYP_CMD);
  assign io_stat_miss     = (state == MISS_CMD) && io_mem_cmd_ready;
  assign dbgState         = state;

  always_comb begin
    io_mem_cmd_payload_address = '0;
    io_mem_cmd_payload_size    = '0;
    if (state == MISS_CMD) begin
      io_mem_cmd_payload_address = {lkWa[29:WRD_W], {OFF_W{1'b0}}};
      io_mem_cmd_payload_size    = 3'(OFF_W);
    end else if (state == BYP_CMD) begin
      io_mem_cmd_payload_address = {lkWa, 2'b00};
      io_mem_cmd_payload_size    = 3'd2;
    end
  end

  assign rdAddr   = {io_req_pc[OFF_W +: IDX_W], io_req_pc[2 +: WRD_W]};
  assign wrAddr   = {lkIdx, beatCnt};
  assign ramWe    = (state == REFILL) && io_mem_rsp_valid;
  assign lineDone = ramWe && (beatCnt == WRD_W'(LINE_WORDS - 1));
  // A line only becomes usable if every beat was clean and no flush arrived during the fill.
  assign lineOk   = !(errAcc || io_mem_rsp_payload_error) && !(flushPend || io_flush);
  assign nextPtr  = (rrPtr[lkIdx] == WAY_W'(WAYS - 1)) ? '0 : rrPtr[lkIdx] + 1'b1;

  for (genvar w = 0; w < WAYS; w++) begin : gWay
    logic [31:0] ram [SETS*LINE_WORDS];
    logic [31:0] q;
    always_ff @(posedge clk) begin
      if (ramWe && victim == WAY_W'(w)) ram[wrAddr] <= io_mem_rsp_payload_data;
      q <= ram[rdAddr];
    end
    assign rdWord[w] = q;
  end

  always_ff @(posedge clk) begin
    if (lineDone && lineOk) tags[victim][lkIdx] <= lkTag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lkValid   <= 1'b0;
      lkBypass  <= 1'b0;
      lkWa      <= '0;
      flushPend <= 1'b0;
      victim    <= '0;
      beatCnt   <= '0;
      errAcc    <= 1'b0;
      capWord   <= '0;
      capErr    <= 1'b0;
      for (int w = 0; w < WAYS; w++) validBits[w] <= '0;
      for (int s = 0; s < SETS; s++) rrPtr[s] <= '0;
    end else begin
      lkValid <= accept;
      if (accept) begin
        lkWa     <= io_req_pc[31:2];
        lkBypass <= io_req_bypass;
      end
      if (state != IDLE && io_flush) flushPend <= 1'b1;
      case (state)
        IDLE: begin
          if (io_flush || flushPend) begin
            for (int w = 0; w < WAYS; w++) validBits[w] <= '0;
            flushPend <= 1'b0;
          end
          if (lookup && lkBypass) state <= BYP_CMD;
          else if (lookup && !hit) begin
            state  <= MISS_CMD;
            victim <= vicSel;
          end
        end
        MISS_CMD: if (io_mem_cmd_ready) begin
          state   <= REFILL;
          beatCnt <= '0;
          errAcc  <= 1'b0;
        end
        REFILL: if (io_mem_rsp_valid) begin
          if (beatCnt == lkWord) capWord <= io_mem_rsp_payload_data;
          errAcc  <= errAcc || io_mem_rsp_payload_error;
          beatCnt <= beatCnt + 1'b1;
          if (lineDone) begin
            state  <= RESP;
            capErr <= errAcc || io_mem_rsp_payload_error;
            if (lineOk) begin
              validBits[victim][lkIdx] <= 1'b1;
              rrPtr[lkIdx]             <= nextPtr;
            end
          end
        end
        BYP_CMD: if (io_mem_cmd_ready) state <= BYP_WAIT;
        BYP_WAIT: if (io_mem_rsp_valid) begin
          capWord <= io_mem_rsp_payload_data;
          capErr  <= io_mem_rsp_payload_error;
          state   <= RESP;
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_nway.sv
// Directed and randomized fetch sequences for icache_nway, checked against a line-level
// model of valid/tag/round-robin state and a fixed memory image.
module tb_icache_nway;
  localparam int WAYS = 2, SETS = 32, LW = 8;

  logic        clk = 1'b0, reset = 1'b1;
  logic        flush = 1'b0, reqValid = 1'b0, reqBypass = 1'b0, cmdReady = 1'b0;
  logic        memRspValid = 1'b0, memErr = 1'b0;
  logic [31:0] reqPc = '0, memData = '0;
  logic        ready, rspValid, rspError, cmdValid, statMiss;
  logic [31:0] rspData, cmdAddr;
  logic [2:0]  cmdSize, dbgState;

  int nAssert = 0, nFail = 0;
  logic [31:0] expQ[$];

  bit          mValid [WAYS][SETS];
  int unsigned mTag   [WAYS][SETS];
  int          mPtr   [SETS];

  always #5 clk = ~clk;

  icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset), .io_flush(flush),
    .io_req_valid(reqValid), .io_req_ready(ready), .io_req_pc(reqPc), .io_req_bypass(reqBypass),
    .io_rsp_valid(rspValid), .io_rsp_data(rspData), .io_rsp_error(rspError),
    .io_mem_cmd_valid(cmdValid), .io_mem_cmd_ready(cmdReady),
    .io_mem_cmd_payload_address(cmdAddr), .io_mem_cmd_payload_size(cmdSize),
    .io_mem_rsp_valid(memRspValid), .io_mem_rsp_payload_data(memData),
    .io_mem_rsp_payload_error(memErr), .io_stat_miss(statMiss), .dbgState(dbgState)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory image: word i of the line at base B holds B + i.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a & ~32'h1F) + ((a >> 2) & 32'h7);
  endfunction

  function automatic bit mHit(input logic [31:0] pc);
    int s = int'((pc >> 5) % SETS);
    for (int w = 0; w < WAYS; w++)
      if (mValid[w][s] && mTag[w][s] == (pc >> 10)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void mFill(input logic [31:0] pc);
    int s = int'((pc >> 5) % SETS);
    int v = -1;
    for (int w = 0; w < WAYS; w++) if (!mValid[w][s] && v < 0) v = w;
    if (v < 0) v = mPtr[s];
    mValid[v][s] = 1'b1;
    mTag[v][s]   = pc >> 10;
    mPtr[s]      = (mPtr[s] + 1) % WAYS;
  endfunction

  function automatic void mFlush();
    for (int w = 0; w < WAYS; w++) for (int s = 0; s < SETS; s++) mValid[w][s] = 1'b0;
  endfunction

  task automatic doReset();
    reset = 1'b0;
    #1;
    chk("rst_req_ready", ready, 0);
    chk("rst_cmd_valid", cmdValid, 0);
    chk("rst_rsp_valid", rspValid, 0);
    chk("rst_rsp_data", rspData, 0);
    chk("rst_rsp_error", rspError, 0);
    chk("rst_stat_miss", statMiss, 0);
    mFlush();
    for (int s = 0; s < SETS; s++) mPtr[s] = 0;
    reqValid = 0; cmdReady = 0; memRspValid = 0; memErr = 0; flush = 0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic doFlush();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    mFlush();
  endtask

  // One fetch; rstAt: -1 none, 0 reset while command pending, k>0 reset after k beats.
  task automatic fetch(input logic [31:0] pc, input bit byp, input int errBeat,
                       input int flushBeat, input int rstAt, input logic [31:0] bypData);
    bit expHit, anyErr, flushed, first;
    int nb, waits;
    logic [31:0] lineBase, expAddr, expData;
    logic [2:0]  expSize;
    expHit   = !byp && mHit(pc);
    nb       = byp ? 1 : LW;
    lineBase = pc & ~32'(LW * 4 - 1);
    expAddr  = byp ? (pc & ~32'h3) : lineBase;
    expSize  = byp ? 3'd2 : 3'd5;
    anyErr   = (errBeat >= 0 && errBeat < nb);
    flushed  = (flushBeat >= 0 && flushBeat < nb);
    expData  = byp ? bypData : memWord(pc);
    reqValid = 1; reqPc = pc; reqBypass = byp;
    @(negedge clk);
    waits = 0;
    while (!ready && waits < 8) begin @(negedge clk); waits++; end
    chk("req_ready", ready, 1);
    @(posedge clk); #1;
    reqValid = 0;
    @(negedge clk);
    if (expHit) begin
      expQ.push_back(memWord(pc));
      chk("hit_rsp_valid", rspValid, 1);
      chk("hit_rsp_data", rspData, expQ.pop_front());
      chk("hit_rsp_error", rspError, 0);
      chk("hit_no_cmd", cmdValid, 0);
      @(posedge clk); #1;
      return;
    end
    chk("lookup_no_rsp", rspValid, 0);
    @(posedge clk); #1;
    if (rstAt == 0) begin
      @(negedge clk);
      chk("cmd_valid_pre_rst", cmdValid, 1);
      #1;
      doReset();
      return;
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("cmd_hold_valid", cmdValid, 1);
      chk("cmd_hold_addr", cmdAddr, expAddr);
      chk("cmd_hold_size", 32'(cmdSize), 32'(expSize));
      chk("cmd_hold_no_stat", statMiss, 0);
      @(posedge clk); #1;
    end
    cmdReady = 1;
    @(negedge clk);
    chk("cmd_valid", cmdValid, 1);
    chk("cmd_addr", cmdAddr, expAddr);
    chk("cmd_size", 32'(cmdSize), 32'(expSize));
    chk("stat_miss", statMiss, byp ? 0 : 1);
    @(posedge clk); #1;
    cmdReady = 0;
    first = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (rstAt > 0 && i == rstAt) begin
        doReset();
        repeat (2) begin
          memRspValid = 1; memData = $urandom;
          @(negedge clk);
          chk("stray_beat_no_rsp", rspValid, 0);
          chk("stray_beat_no_cmd", cmdValid, 0);
          @(posedge clk); #1;
        end
        memRspValid = 0;
        return;
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("gap_no_rsp", rspValid, 0);
        if (first) chk("cmd_drop", cmdValid, 0);
        first = 1'b0;
        @(posedge clk); #1;
      end
      memRspValid = 1;
      memData = byp ? bypData : memWord(lineBase + 32'(4 * i));
      memErr  = (i == errBeat);
      flush   = (i == flushBeat);
      @(negedge clk);
      chk("beat_no_rsp", rspValid, 0);
      if (first) chk("cmd_drop", cmdValid, 0);
      first = 1'b0;
      @(posedge clk); #1;
      memRspValid = 0; memErr = 0; flush = 0;
    end
    expQ.push_back(expData);
    @(negedge clk);
    chk("miss_rsp_valid", rspValid, 1);
    chk("miss_rsp_data", rspData, expQ.pop_front());
    chk("miss_rsp_error", rspError, 32'(anyErr));
    if (flushed) mFlush();
    else if (!byp && !anyErr) mFill(pc);
    @(posedge clk); #1;
    if (flushed) begin
      @(negedge clk);
      chk("pending_flush_ready_low", ready, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d assertions evaluated", nAssert);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc;
    bit byp;
    int eb, fb;
    #2;
    doReset();

    // Cold miss then hit in the same line.
    fetch(32'h0000_1014, 0, -1, -1, -1, 0);
    fetch(32'h0000_1018, 0, -1, -1, -1, 0);

    // Back-to-back hits across the whole line.
    for (int k = 0; k < 8; k++) begin
      reqValid = 1; reqPc = 32'h1000 + 32'(4 * k); reqBypass = 0;
      @(negedge clk);
      chk("b2b_ready", ready, 1);
      chk("b2b_no_cmd", cmdValid, 0);
      if (k > 0) begin
        expQ.push_back(memWord(32'h1000 + 32'(4 * (k - 1))));
        chk("b2b_rsp_valid", rspValid, 1);
        chk("b2b_rsp_data", rspData, expQ.pop_front());
      end
      @(posedge clk); #1;
    end
    reqValid = 0;
    @(negedge clk);
    expQ.push_back(32'h0000_1007);
    chk("b2b_last_valid", rspValid, 1);
    chk("b2b_last_data", rspData, expQ.pop_front());
    @(posedge clk); #1;

    // Round-robin replacement within set 0.
    fetch(32'h0000_0000, 0, -1, -1, -1, 0);
    fetch(32'h0000_0400, 0, -1, -1, -1, 0);
    fetch(32'h0000_0800, 0, -1, -1, -1, 0);
    fetch(32'h0000_0400, 0, -1, -1, -1, 0);
    fetch(32'h0000_0000, 0, -1, -1, -1, 0);
    fetch(32'h0000_0800, 0, -1, -1, -1, 0);

    // Error beat: flagged and not allocated.
    fetch(32'h0000_2000, 0, 3, -1, -1, 0);
    fetch(32'h0000_2000, 0, -1, -1, -1, 0);

    // Flush during refill.
    fetch(32'h0000_1000, 0, -1, -1, -1, 0);
    fetch(32'h0000_4020, 0, -1, 4, -1, 0);
    fetch(32'h0000_1000, 0, -1, -1, -1, 0);
    fetch(32'h0000_4020, 0, -1, -1, -1, 0);

    // Idle flush, then everything misses again.
    doFlush();
    fetch(32'h0000_1004, 0, -1, -1, -1, 0);

    // Bypass never allocates.
    fetch(32'h0000_3006, 1, -1, -1, -1, 32'hDEAD_BEEF);
    fetch(32'h0000_3006, 1, -1, -1, -1, 32'h1234_5678);
    fetch(32'h0000_3008, 1, 0, -1, -1, 32'h0BAD_0BAD);

    // Reset while a command is pending and mid-refill.
    fetch(32'h0000_5000, 0, -1, -1, 0, 0);
    fetch(32'h0000_1014, 0, -1, -1, -1, 0);
    fetch(32'h0000_6040, 0, -1, -1, 3, 0);
    fetch(32'h0000_1014, 0, -1, -1, -1, 0);
    fetch(32'h0000_6040, 0, -1, -1, -1, 0);

    // Randomized traffic over a few conflicting lines.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 19) == 0) doFlush();
      else begin
        pc  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 5) |
              (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
        byp = ($urandom_range(0, 9) == 0);
        eb  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, byp ? 0 : LW - 1)) : -1;
        fb  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, byp ? 0 : LW - 1)) : -1;
        fetch(pc, byp, eb, fb, -1, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised N-way set-associative instruction cache, the next generation of the core's single-configuration fetch cache. It sits between the fetch stage and the instruction memory bus. It serves 32-bit instruction words with single-cycle hit latency and refills whole lines with one burst command. It adds configurable ways, sets and line length, round-robin replacement, an uncached bypass path and error-tagged responses.

## Interface
- WAYS, 2, associativity; power of two, 1..8
- SETS, 32, sets per way; power of two, ≥2
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..16
- Derived fields: offset = log2(LINE_WORDS*4) bits; index = log2(SETS) bits; tag = the remaining bits of 32.

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; low = in reset
- io_flush  in  1  invalidate all lines
- io_req_valid  in  1  fetch request
- io_req_ready  out  1  request accepted when valid&ready
- io_req_pc  in  32  byte address; bits[1:0] ignored
- io_req_bypass  in  1  uncached single-word fetch, no allocation
- io_rsp_valid  out  1  one-cycle response pulse; consumer always accepts
- io_rsp_data  out  32  instruction word
- io_rsp_error  out  1  bus error on the word or line
- io_mem_cmd_valid  out  1  bus command
- io_mem_cmd_ready  in  1  command accept
- io_mem_cmd_payload_address  out  32  line-aligned (refill) or word-aligned (bypass)
- io_mem_cmd_payload_size  out  3  log2 bytes: offset width (refill) or 2 (bypass)
- io_mem_rsp_valid  in  1  read beat, in address order
- io_mem_rsp_payload_data  in  32  beat data
- io_mem_rsp_payload_error  in  1  beat error
- io_stat_miss  out  1  one-cycle pulse per refill command issued

## Operation
- Storage:
  - valid and tag bits are held in flops.
  - Data array: WAYS×SETS×LINE_WORDS words with a synchronous read.
  - Round-robin pointer per set: log2(WAYS) bits.
- FSM states: IDLE, MISS_CMD, REFILL, BYP_CMD, BYP_WAIT, RESP.
- IDLE:
  - io_req_ready = 1, except when io_flush=1, when a flush is pending, or when the lookup stage holds a miss or a bypass.
  - An accepted request is registered into the lookup stage.
- Lookup, the cycle after accept:
  - Hit (valid && tag match in any way) → io_rsp_valid=1 with that way's word, error=0.
  - Miss → MISS_CMD.
  - Bypass → BYP_CMD.
- MISS_CMD: hold the command until ready, with address = {pc[31:offset], 0} and size = offset width. On accept → REFILL; io_stat_miss pulses in the accept cycle.
- Victim selection: the lowest-numbered invalid way in the set; if every way is valid, the pointer way.
- REFILL:
  - Beat counter counts 0..LINE_WORDS-1; each beat is written to victim[set][count].
  - The beat matching pc word is captured for the response.
  - Errors are OR-ed across all beats.
  - After the last beat → RESP.
  - If there was no error and no flush pending: the victim gets valid=1 and tag set, and the set pointer advances by one modulo WAYS.
  - Otherwise the victim stays invalid and the pointer is unchanged.
- BYP_CMD / BYP_WAIT: a single-word command with size 2. The one beat is captured → RESP. No array or pointer change.
- RESP: io_rsp_valid=1 with the captured word and error → IDLE.
- Flush:
  - In IDLE: clears all valid bits in one cycle. Pointers are not reset.
  - A lookup hit in the flush cycle still responds with the old data.
  - Flush during MISS/REFILL/BYP: latched as pending. The refill completes but does not set valid. All valids are cleared on return to IDLE, and ready stays 0 during that cycle.
- Reset (asynchronous, any state):
  - State → IDLE; all valids, pointers, counter and pending flush cleared.
  - An in-flight bus transaction is abandoned; beats arriving after reset release are ignored.

## Timing
- Reset values: io_rsp_valid, io_rsp_error, io_mem_cmd_valid and io_stat_miss = 0; io_rsp_data = 0; io_req_ready = 0 while reset is low.
- Hit latency: response 1 cycle after accept. Back-to-back hits give one response per cycle.
- Miss latency: command valid 1 cycle after lookup; response 1 cycle after the last beat.
- Bypass: response 1 cycle after its beat.
- Command handshake:
  - Address and size are stable while valid && !ready.
  - Valid drops the cycle after accept.
  - Response beats arrive no earlier than the cycle after command accept.

## Test plan
- Cold miss, default parameters: pc 0x0000_1014 → cmd address 0x0000_1000, size 5, stat_miss pulse. Send 8 beats with data 0x1000+i → rsp_data 0x1005, error 0, one cycle after beat 7. Then pc 0x1018 → hit with data 0x1006, latency 1.
- Back-to-back hits: pcs 0x1000..0x101C requested on consecutive cycles → 8 consecutive responses, data 0x1000..0x1007, no bus command.
- Replacement: fill 0x0000 and 0x0400 (set 0, ways 0/1); 0x0800 evicts way 0. Then 0x0400 hits, and 0x0000 misses and refills into way 1.
- Error: error on beat 3 of the 0x2000 refill → rsp_error=1; a repeat of 0x2000 misses again.
- Flush during refill at beat 4 → response is still delivered; afterwards 0x1000 and the refilled line both miss, and ready is low for one cycle after RESP.
- Bypass pc 0x3006 → cmd address 0x3004, size 2; beat 0xDEAD_BEEF → rsp; a repeat of the request issues a new command. Reset asserted mid-refill → cmd_valid 0 at once, then all lines miss.
